// File: rtl/afe_spi_writer.sv
// afe_spi_writer: serial word writer for AFE boards, one CLK/SDI/LE lane per board.
module afe_spi_writer #(
    parameter int CLK_RATE      = 99999001,
    parameter int SPI_RATE      = 10000000,
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNEL_COUNT = 2,
    parameter int CHSEL_WIDTH   = 1
) (
    input  logic                     sysClk,
    input  logic                     sysReset,
    input  logic                     start,
    input  logic [CHSEL_WIDTH-1:0]   channel,
    input  logic [DATA_WIDTH-1:0]    data,
    input  logic                     clearErrors,
    output logic                     busy,
    output logic                     overrun,
    output logic                     badChannel,
    output logic [CHANNEL_COUNT-1:0] AFE_SPI_CLK,
    output logic [CHANNEL_COUNT-1:0] AFE_SPI_SDI,
    output logic [CHANNEL_COUNT-1:0] AFE_SPI_LE
);
    localparam longint HQ = (longint'(CLK_RATE) + longint'(2) * longint'(SPI_RATE) - longint'(1))
                            / (longint'(2) * longint'(SPI_RATE));
    localparam int HALF = (HQ < longint'(1)) ? 1 : int'(HQ);
    localparam int TW = $clog2(HALF + 1);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, CLK_LO, CLK_HI, SETTLE, LATCH, GAP} state_t;

    state_t                   state_q, state_d;
    logic [TW-1:0]            tick_q, tick_d;
    logic [BW-1:0]            bits_q, bits_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d;
    logic [CHSEL_WIDTH-1:0]   chan_q, chan_d;
    logic                     busy_q, busy_d, ovr_q, ovr_d, bad_q, bad_d;
    logic [CHANNEL_COUNT-1:0] clk_q, clk_d, sdi_q, sdi_d, le_q, le_d, lane;
    logic                     last, ch_ok;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        chan_d  = chan_q;
        last    = tick_q == TW'(HALF - 1);
        ch_ok   = 32'(channel) < 32'(CHANNEL_COUNT);
        ovr_d   = (start && busy_q) || (ovr_q && !clearErrors);
        bad_d   = (start && !ch_ok) || (bad_q && !clearErrors);
        if (state_q == IDLE) begin
            if (start && ch_ok) begin
                state_d = CLK_LO;
                tick_d  = '0;
                bits_d  = BW'(DATA_WIDTH - 1);
                shift_d = data;
                chan_d  = channel;
            end
        end else begin
            tick_d = last ? '0 : tick_q + TW'(1);
            if (last) begin
                case (state_q)
                    CLK_LO: state_d = CLK_HI;
                    CLK_HI: begin
                        shift_d = shift_q << 1;
                        bits_d  = bits_q - BW'(1);
                        state_d = (bits_q == '0) ? SETTLE : CLK_LO;
                    end
                    SETTLE: state_d = LATCH;
                    LATCH:  state_d = GAP;
                    default: state_d = IDLE;
                endcase
            end
        end
        // pins are registered from the next state so each lane switches cleanly on the edge
        lane   = CHANNEL_COUNT'(1) << chan_d;
        busy_d = state_d != IDLE;
        clk_d  = (state_d == CLK_HI) ? lane : '0;
        sdi_d  = ((state_d == CLK_LO || state_d == CLK_HI) && shift_d[DATA_WIDTH-1]) ? lane : '0;
        le_d   = (state_d == LATCH) ? lane : '0;
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            chan_q  <= '0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            bad_q   <= 1'b0;
            clk_q   <= '0;
            sdi_q   <= '0;
            le_q    <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            chan_q  <= chan_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            bad_q   <= bad_d;
            clk_q   <= clk_d;
            sdi_q   <= sdi_d;
            le_q    <= le_d;
        end
    end

    assign busy        = busy_q;
    assign overrun     = ovr_q;
    assign badChannel  = bad_q;
    assign AFE_SPI_CLK = clk_q;
    assign AFE_SPI_SDI = sdi_q;
    assign AFE_SPI_LE  = le_q;
endmodule

// File: tb/tb_afe_spi_writer.sv
// tb_afe_spi_writer: waveform-level checks of three writer configurations against a phase model.
module tb_afe_spi_writer;
    logic       clk, sysReset, clearErrors;
    logic [2:0] start_v;
    logic [1:0] channel;
    logic [7:0] data;
    int         sel, checks, errors;

    logic       a_busy, a_ovr, a_bad, b_busy, b_ovr, b_bad, c_busy, c_ovr, c_bad;
    logic [1:0] a_clk, a_sdi, a_le, c_clk, c_sdi, c_le;
    logic [2:0] b_clk, b_sdi, b_le;
    logic [9:0] obs;

    afe_spi_writer u_a (
        .sysClk(clk), .sysReset(sysReset), .start(start_v[0]), .channel(channel[0:0]), .data(data),
        .clearErrors(clearErrors), .busy(a_busy), .overrun(a_ovr), .badChannel(a_bad),
        .AFE_SPI_CLK(a_clk), .AFE_SPI_SDI(a_sdi), .AFE_SPI_LE(a_le));

    afe_spi_writer #(.CHANNEL_COUNT(3), .CHSEL_WIDTH(2)) u_b (
        .sysClk(clk), .sysReset(sysReset), .start(start_v[1]), .channel(channel), .data(data),
        .clearErrors(clearErrors), .busy(b_busy), .overrun(b_ovr), .badChannel(b_bad),
        .AFE_SPI_CLK(b_clk), .AFE_SPI_SDI(b_sdi), .AFE_SPI_LE(b_le));

    afe_spi_writer #(.SPI_RATE(99999001)) u_c (
        .sysClk(clk), .sysReset(sysReset), .start(start_v[2]), .channel(channel[0:0]), .data(data),
        .clearErrors(clearErrors), .busy(c_busy), .overrun(c_ovr), .badChannel(c_bad),
        .AFE_SPI_CLK(c_clk), .AFE_SPI_SDI(c_sdi), .AFE_SPI_LE(c_le));

    assign obs = (sel == 0) ? {1'b0, a_clk, 1'b0, a_sdi, 1'b0, a_le, a_busy} :
                 (sel == 1) ? {b_clk, b_sdi, b_le, b_busy} :
                              {1'b0, c_clk, 1'b0, c_sdi, 1'b0, c_le, c_busy};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 19 phases of h cycles: 16 clock half-periods, settle, latch, gap
    function automatic logic [9:0] model(input int w, input int c, input int h, input int k);
        int p = k / h;
        logic [2:0] ln = 3'(1 << c);
        logic [2:0] ck, sd, le;
        if (k >= 19 * h) return '0;
        ck = (p < 16 && p % 2 == 1) ? ln : 3'b0;
        sd = (p < 16 && ((w >> (7 - p / 2)) & 1) != 0) ? ln : 3'b0;
        le = (p == 17) ? ln : 3'b0;
        return {ck, sd, le, 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic xfer(input int d, input int w, input int c, input int extra);
        int h = (d == 2) ? 1 : 5;
        sel = d;
        start_v[d] = 1'b1;
        data = 8'(w);
        channel = 2'(c);
        @(negedge clk);
        start_v[d] = 1'b0;
        for (int k = 0; k <= 19 * h; k++) begin
            chk($sformatf("xfer dut%0d w=%02h ch%0d k=%0d", d, w, c, k), 32'(obs), 32'(model(w, c, h, k)));
            if (extra >= 0) begin
                start_v[d] = (k == extra);
                data = 8'h00;
            end
            if (k < 19 * h) @(negedge clk);
        end
    endtask

    initial begin
        logic le_seen;
        checks = 0;
        errors = 0;
        sysReset = 1'b1;
        clearErrors = 1'b0;
        start_v = '0;
        channel = '0;
        data = '0;
        sel = 0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1 chk($sformatf("reset pins dut%0d", d), 32'(obs), 32'h0);
        end
        chk("reset flags", 32'({a_ovr, a_bad, b_ovr, b_bad, c_ovr, c_bad}), 32'h0);
        sysReset = 1'b0;
        @(negedge clk);

        xfer(0, 'hA5, 0, -1);
        @(negedge clk);
        xfer(0, 'hFF, 1, 20);
        chk("overrun set", 32'(a_ovr), 32'h1);
        clearErrors = 1'b1;
        @(negedge clk);
        clearErrors = 1'b0;
        chk("overrun cleared", 32'(a_ovr), 32'h0);

        xfer(0, 'h10, 0, -1);
        xfer(0, 'h3C, 1, -1);
        chk("no overrun back-to-back", 32'(a_ovr), 32'h0);

        @(negedge clk);
        sel = 0;
        start_v[0] = 1'b1;
        data = 8'hC3;
        channel = 2'd0;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (42) @(negedge clk);
        sysReset = 1'b1;
        @(negedge clk);
        chk("abort pins", 32'(obs), 32'h0);
        sysReset = 1'b0;
        le_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            le_seen = le_seen | (|a_le) | a_busy;
        end
        chk("abort no LE", 32'(le_seen), 32'h0);
        xfer(0, 'h5A, 1, -1);

        @(negedge clk);
        sel = 1;
        start_v[1] = 1'b1;
        channel = 2'd3;
        data = 8'hAA;
        @(negedge clk);
        start_v[1] = 1'b0;
        chk("badChannel set", 32'(b_bad), 32'h1);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bad ch idle k=%0d", k), 32'(obs), 32'h0);
            @(negedge clk);
        end
        clearErrors = 1'b1;
        @(negedge clk);
        clearErrors = 1'b0;
        chk("badChannel cleared", 32'(b_bad), 32'h0);
        xfer(1, 'h96, 2, -1);

        xfer(2, 'h81, 0, -1);
        repeat (4) xfer(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), -1);
        repeat (4) xfer(2, int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), -1);
        repeat (3) xfer(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 2)), -1);
        chk("final flags", 32'({a_ovr, a_bad, b_ovr, b_bad, c_ovr, c_bad}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/afe_spi_writer.md
Name: afe_spi_writer

Overview:
- Write-only serial controller for the analog front-end attenuator/switch boards.
- Drives the top-level AFE_SPI_CLK / AFE_SPI_SDI / AFE_SPI_LE pin vectors, one lane per AFE board.
- Accepts a single-cycle write request (data word plus board select) from the system-clock CSR logic, shifts the word MSB-first on the selected lane, then pulses that lane's latch enable.
- Sits directly upstream of the AFE pins in the common top.

Parameters:
- CLK_RATE, 99999001: sysClk frequency in Hz.
- SPI_RATE, 10000000: maximum serial clock frequency in Hz.
- DATA_WIDTH, 8: bits per transfer.
- CHANNEL_COUNT, 2: number of AFE lanes.
- CHSEL_WIDTH, 1: width of the board-select input; must satisfy 2**CHSEL_WIDTH >= CHANNEL_COUNT.

Ports:
- sysClk, input, 1: system clock; all logic in this domain.
- sysReset, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle write request.
- channel, input, CHSEL_WIDTH: target lane, sampled with start.
- data, input, DATA_WIDTH: word to send, sampled with start.
- clearErrors, input, 1: clears the sticky overrun and badChannel flags.
- busy, output, 1: transfer in progress.
- overrun, output, 1: sticky; set when start arrives while busy.
- badChannel, output, 1: sticky; set when start arrives with channel >= CHANNEL_COUNT.
- AFE_SPI_CLK, output, CHANNEL_COUNT: serial clock per lane.
- AFE_SPI_SDI, output, CHANNEL_COUNT: serial data per lane.
- AFE_SPI_LE, output, CHANNEL_COUNT: latch enable per lane.

Behaviour:
- Clock and reset: single clock sysClk; synchronous, active-high reset sysReset.
- Reset state: all outputs are 0 and the state machine is IDLE. sysReset asserted mid-transfer aborts the transfer; pins go low on the next edge and no LE pulse is produced.
- HALF: HALF = ceil(CLK_RATE / (2*SPI_RATE)), computed at elaboration, minimum 1. Defaults give HALF = 5. A tick counter counts HALF cycles per phase.
- States:
  - IDLE: on start with busy=0 and channel valid, latch data into a shift register, latch channel, set busy=1 on the next edge, go to CLK_LO.
  - CLK_LO (HALF cycles): CLK low; SDI of the selected lane = shift-register MSB, driven from the first cycle of the phase. Then go to CLK_HI.
  - CLK_HI (HALF cycles): CLK high; SDI stable. At exit, shift left by one and decrement the bit counter. If bits remain, go to CLK_LO; otherwise go to SETTLE.
  - SETTLE (HALF cycles): CLK low, SDI low. Then go to LATCH.
  - LATCH (HALF cycles): LE=1 on the selected lane only. Then go to GAP.
  - GAP (HALF cycles): all pins low. Then go to IDLE; busy=0 on entry to IDLE.
- Total busy time is (2*DATA_WIDTH + 3)*HALF cycles. Defaults: 95 cycles.
- Unselected lanes hold CLK, SDI and LE at 0 for the whole transfer.
- The slave samples SDI on the rising CLK edge. SDI changes only at CLK_LO entry, giving a HALF-cycle setup before the rising edge and a HALF-cycle hold after it.
- Pin outputs are registered: no combinational path from state to pins, so they are glitch-free.
- start while busy: ignored; overrun is set.
- start with channel >= CHANNEL_COUNT: ignored, no transfer; badChannel is set.
- start on the same cycle busy falls (first IDLE cycle): accepted normally.
- clearErrors coincident with a new error event: the set wins.
- data and channel are don't-care when start=0.

Test Plan:
- Reset, then start with channel=0, data=0xA5, default parameters -> lane0 shows 8 rising CLK edges with SDI = 1,0,1,0,0,1,0,1 at each rising edge; CLK period 10 cycles; one LE pulse 5 cycles wide beginning 5 cycles after the last falling CLK edge; busy high exactly 95 cycles; lane1 pins stay 0 throughout.
- start with channel=1, data=0xFF, then a second start 20 cycles later with data=0x00 -> only 0xFF is shifted on lane1; overrun=1; clearErrors -> overrun=0.
- start with channel=1, data=0x3C issued on the first cycle after busy falls from a prior transfer -> the transfer is accepted; busy rises on the next cycle; no overrun.
- Assert sysReset during bit 4 of a transfer -> all pins and busy are 0 one cycle later; no LE pulse; a following start completes normally.
- Set CHANNEL_COUNT=3, CHSEL_WIDTH=2, then start with channel=3 -> no pin activity; busy stays 0; badChannel=1.
- Set SPI_RATE=CLK_RATE (HALF=1), then start with data=0x81 -> CLK period 2 cycles; busy high for 19 cycles; correct bit sequence 1,0,0,0,0,0,0,1.
